// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes and debounces active-low pushbuttons.
// Ports:
//   clk, rst_n - clock and async active-low reset
//   key_n      - raw active-low keys (asynchronous)
//   key_level  - debounced active-high key state
//   key_press  - one-cycle strobe on an accepted press
//   key_release- one-cycle strobe on an accepted release
module key_debouncer #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_KEYS-1:0]            s1_q, s1_d;
    logic [N_KEYS-1:0]            s2_q, s2_d;
    logic [N_KEYS-1:0]            stable_q, stable_d;
    logic [N_KEYS-1:0]            press_q, press_d;
    logic [N_KEYS-1:0]            release_q, release_d;
    logic [N_KEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_KEYS-1:0]            cand;

    // Active-high view of the synchronized key.
    assign cand = ~s2_q;

    always_comb begin
        s1_d      = key_n;
        s2_d      = s1_q;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (cand[i] == stable_q[i]) begin
                // Any return to the accepted level restarts the count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i]  = cand[i];
                cnt_d[i]     = '0;
                press_d[i]   = cand[i];
                release_d[i] = ~cand[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '1;
            s2_q      <= '1;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign key_level   = stable_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed checks of key_debouncer with
// DEBOUNCE_CYCLES=4, N_KEYS=2 (accept 6 edges after first sample).
module tb_key_debouncer;

    localparam int N = 2;
    localparam int D = 4;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] key_n;
    logic [N-1:0] key_level;
    logic [N-1:0] key_press;
    logic [N-1:0] key_release;

    int tests = 0;
    int fails = 0;

    key_debouncer #(
        .N_KEYS(N),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_n(key_n),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        key_n = 2'b11;
        #2;
        step();
        step();
        tests++;
        if ({key_level, key_press, key_release} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {key_level, key_press, key_release}, 6'b0);
        end
        rst_n = 1'b1;
        step();
        step();
        tests++;
        if ({key_level, key_press, key_release} !== 6'b0) begin
            fails++;
            $display("FAIL reset_idle: got %b expected %b",
                     {key_level, key_press, key_release}, 6'b0);
        end
    endtask

    task automatic test_clean_press();
        logic [N-1:0] ep, el;
        key_n = 2'b10;
        for (int s = 1; s <= 7; s++) begin
            step();
            ep = (s == 6) ? 2'b01 : 2'b00;
            el = (s >= 6) ? 2'b01 : 2'b00;
            tests++;
            if (key_press !== ep) begin
                fails++;
                $display("FAIL clean_press step %0d: key_press=%b expected %b",
                         s, key_press, ep);
            end
            tests++;
            if (key_level !== el) begin
                fails++;
                $display("FAIL clean_level step %0d: key_level=%b expected %b",
                         s, key_level, el);
            end
            tests++;
            if (key_release !== 2'b00) begin
                fails++;
                $display("FAIL clean_release step %0d: key_release=%b expected 00",
                         s, key_release);
            end
        end
        for (int s = 0; s < 4; s++) begin
            step();
            tests++;
            if (key_press !== 2'b00 || key_level !== 2'b01) begin
                fails++;
                $display("FAIL clean_hold step %0d: press=%b level=%b expected 00/01",
                         s, key_press, key_level);
            end
        end
    endtask

    task automatic test_release();
        logic [N-1:0] er, el;
        key_n = 2'b11;
        for (int s = 1; s <= 7; s++) begin
            step();
            er = (s == 6) ? 2'b01 : 2'b00;
            el = (s >= 6) ? 2'b00 : 2'b01;
            tests++;
            if (key_release !== er) begin
                fails++;
                $display("FAIL release_strobe step %0d: key_release=%b expected %b",
                         s, key_release, er);
            end
            tests++;
            if (key_level !== el) begin
                fails++;
                $display("FAIL release_level step %0d: key_level=%b expected %b",
                         s, key_level, el);
            end
            tests++;
            if (key_press !== 2'b00) begin
                fails++;
                $display("FAIL release_press step %0d: key_press=%b expected 00",
                         s, key_press);
            end
        end
    endtask

    task automatic test_bounce();
        logic [N-1:0] ep, el;
        key_n = 2'b10;
        for (int s = 1; s <= 4; s++) begin
            if (s == 4) key_n = 2'b11;
            step();
            tests++;
            if (key_press !== 2'b00 || key_level !== 2'b00) begin
                fails++;
                $display("FAIL bounce_glitch step %0d: press=%b level=%b expected 00/00",
                         s, key_press, key_level);
            end
        end
        key_n = 2'b10;
        for (int s = 1; s <= 7; s++) begin
            step();
            ep = (s == 6) ? 2'b01 : 2'b00;
            el = (s >= 6) ? 2'b01 : 2'b00;
            tests++;
            if (key_press !== ep || key_level !== el) begin
                fails++;
                $display("FAIL bounce_press step %0d: press=%b level=%b expected %b/%b",
                         s, key_press, key_level, ep, el);
            end
        end
        key_n = 2'b11;
        for (int s = 0; s < 8; s++) step();
        tests++;
        if (key_level !== 2'b00) begin
            fails++;
            $display("FAIL bounce_settle: key_level=%b expected 00", key_level);
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] ep, el, er;
        key_n = 2'b00;
        for (int s = 1; s <= 7; s++) begin
            step();
            ep = (s == 6) ? 2'b11 : 2'b00;
            el = (s >= 6) ? 2'b11 : 2'b00;
            tests++;
            if (key_press !== ep || key_level !== el) begin
                fails++;
                $display("FAIL simul_press step %0d: press=%b level=%b expected %b/%b",
                         s, key_press, key_level, ep, el);
            end
        end
        key_n = 2'b11;
        for (int s = 1; s <= 7; s++) begin
            step();
            er = (s == 6) ? 2'b11 : 2'b00;
            el = (s >= 6) ? 2'b00 : 2'b11;
            tests++;
            if (key_release !== er || key_level !== el || key_press !== 2'b00) begin
                fails++;
                $display("FAIL simul_release step %0d: rel=%b level=%b press=%b expected %b/%b/00",
                         s, key_release, key_level, key_press, er, el);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ep, el;
        key_n = 2'b10;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({key_level, key_press, key_release} !== 6'b0) begin
            fails++;
            $display("FAIL reset_mid_assert: got %b expected %b",
                     {key_level, key_press, key_release}, 6'b0);
        end
        for (int s = 0; s < 2; s++) begin
            step();
            tests++;
            if ({key_level, key_press, key_release} !== 6'b0) begin
                fails++;
                $display("FAIL reset_mid_hold %0d: got %b expected %b",
                         s, {key_level, key_press, key_release}, 6'b0);
            end
        end
        rst_n = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            step();
            ep = (s == 6) ? 2'b01 : 2'b00;
            el = (s >= 6) ? 2'b01 : 2'b00;
            tests++;
            if (key_press !== ep || key_level !== el || key_release !== 2'b00) begin
                fails++;
                $display("FAIL reset_mid_press step %0d: press=%b level=%b rel=%b expected %b/%b/00",
                         s, key_press, key_level, key_release, ep, el);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 2'b11;
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
